// File: rtl/deserializador.sv
// Serial-to-parallel receiver: hunts for SYNC at any bit offset, then delivers
// aligned WIDTH-bit words MSB first and drops lock after MAX_GAP words without SYNC.
module deserializador #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] SYNC    = 8'hBC,
    parameter int               MAX_GAP = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             locked,
    output logic             sync_det
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = $clog2(MAX_GAP + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, dout_n, win;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic             valid_n, sync_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= HUNT;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            data_out <= '0;
            valid    <= 1'b0;
            sync_det <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_n;
            gap_cnt  <= gap_n;
            data_out <= dout_n;
            valid    <= valid_n;
            sync_det <= sync_n;
        end
    end

    // The incoming bit completes the window, so matching and delivery see it on its own edge.
    assign win = {shreg[WIDTH-2:0], serial_in};

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        gap_n   = gap_cnt;
        dout_n  = data_out;
        valid_n = 1'b0;
        sync_n  = 1'b0;
        if (enb) begin
            shreg_n = win;
            case (state)
                HUNT: begin
                    if (win == SYNC) begin
                        state_n = LOCKED;
                        sync_n  = 1'b1;
                        bit_n   = '0;
                        gap_n   = '0;
                    end
                end
                LOCKED: begin
                    if (bit_cnt == BW'(WIDTH - 1)) begin
                        bit_n = '0;
                        if (win == SYNC) begin
                            sync_n = 1'b1;
                            gap_n  = '0;
                        end else begin
                            dout_n  = win;
                            valid_n = 1'b1;
                            gap_n   = gap_cnt + GW'(1);
                            // The word that exhausts the gap budget is still delivered.
                            if (gap_cnt == GW'(MAX_GAP - 1)) begin
                                state_n = HUNT;
                                gap_n   = '0;
                            end
                        end
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_deserializador.sv
// Scoreboard bench for deserializador: directed words push expected bytes,
// a monitor pops and compares on every valid strobe.
module tb_deserializador;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enb = 1'b0;
    logic       serial_in = 1'b0;
    logic [7:0] data_out;
    logic       valid, locked, sync_det;

    int total = 0;
    int bad = 0;
    int sync_cnt = 0;
    bit gaps = 0;
    logic prev_v = 1'b0;
    logic [7:0] expq[$];

    deserializador dut (
        .clk(clk), .reset(reset), .enb(enb), .serial_in(serial_in),
        .data_out(data_out), .valid(valid), .locked(locked), .sync_det(sync_det)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid cycle must match the head of the queue and be a single-cycle pulse.
    always @(negedge clk) begin
        if (valid) begin
            logic [7:0] e;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got data %0h want no valid", data_out);
            end else begin
                e = expq.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL data: got %0h want %0h", data_out, e);
                end
            end
            total++;
            if (prev_v) begin
                bad++;
                $display("FAIL valid_width: got 2-cycle valid want 1-cycle");
            end
        end
        if (sync_det) sync_cnt++;
        prev_v = valid;
    end

    task automatic send_bit(input logic b);
        if (gaps) begin
            @(negedge clk); enb = 1'b0; serial_in = ~b;
        end
        @(negedge clk); enb = 1'b1; serial_in = b;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); enb = 1'b0; serial_in = 1'b0; end
    endtask

    task automatic do_reset();
        @(negedge clk); enb = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic run_t2(input bit g);
        logic [18:0] seq;
        int base;
        seq = {3'b101, 8'hBC, 8'h88};
        gaps = g;
        do_reset();
        base = sync_cnt;
        expq.push_back(8'h88);
        for (int i = 18; i >= 0; i--) begin
            send_bit(seq[i]);
            if (19 - i == 10) chk("t2_unlocked_b10", locked, 0);
            if (19 - i == 11) begin
                chk("t2_locked_b11", locked, 1);
                chk("t2_sync_det_b11", sync_det, 1);
            end
            if (19 - i == 18) chk("t2_novalid_b18", valid, 0);
            if (19 - i == 19) begin
                chk("t2_valid_b19", valid, 1);
                chk("t2_data_b19", data_out, 8'h88);
            end
        end
        idle(3);
        gaps = 0;
        chk("t2_sync_count", sync_cnt - base, 1);
        chk("t2_q_empty", expq.size(), 0);
    endtask

    initial begin
        int base;
        // T1: reset state, async reset mid-word, no lock without SYNC
        repeat (2) @(negedge clk);
        chk("t1_rst_data", data_out, 0);
        chk("t1_rst_valid", valid, 0);
        chk("t1_rst_locked", locked, 0);
        reset = 1'b0;
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h88 >> i));
        #2 reset = 1'b1;
        #1;
        chk("t1_async_data", data_out, 0);
        chk("t1_async_locked", locked, 0);
        @(negedge clk); reset = 1'b0;
        send_byte(8'h88);
        idle(3);
        chk("t1_no_lock", locked, 0);

        // T2 / T3: junk, SYNC, data; then again with enb toggling
        run_t2(0);
        run_t2(1);

        // T4: SYNC words between data are filtered
        do_reset();
        base = sync_cnt;
        expq.push_back(8'hA5);
        expq.push_back(8'h3C);
        send_byte(8'hBC);
        send_byte(8'hA5);
        send_byte(8'hBC);
        chk("t4_hold_a5", data_out, 8'hA5);
        send_byte(8'h3C);
        idle(3);
        chk("t4_sync_count", sync_cnt - base, 2);
        chk("t4_q_empty", expq.size(), 0);

        // T5: lock loss after 16 data words, then relock
        do_reset();
        send_byte(8'hBC);
        for (int w = 1; w <= 16; w++) begin
            expq.push_back(8'h00);
            send_byte(8'h00);
            if (w == 15) chk("t5_locked_w15", locked, 1);
            if (w == 16) begin
                chk("t5_unlocked_w16", locked, 0);
                chk("t5_valid_w16", valid, 1);
            end
        end
        send_byte(8'h55);
        chk("t5_hunt_after_55", locked, 0);
        send_byte(8'hBC);
        chk("t5_relock", locked, 1);
        expq.push_back(8'h3C);
        send_byte(8'h3C);
        idle(3);
        chk("t5_q_empty", expq.size(), 0);

        // T6: reset during a partial word while locked
        do_reset();
        expq.push_back(8'h5A);
        send_byte(8'hBC);
        send_byte(8'h5A);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'hF0 >> i));
        #2 reset = 1'b1;
        #1;
        chk("t6_async_data", data_out, 0);
        chk("t6_async_locked", locked, 0);
        chk("t6_async_valid", valid, 0);
        @(negedge clk); reset = 1'b0;
        for (int i = 3; i >= 0; i--) send_bit(1'(8'hF0 >> i));
        send_byte(8'h00);
        idle(3);
        chk("t6_unlocked", locked, 0);
        chk("t6_q_empty", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
